// File: rtl/nv_fifo_ctrl_pkg.sv
// Shared constants and types for the nv_fifo_ctrl 16x256 FIFO controller.
// DEPTH/DW are the default geometry; AW/CNTW size the pointers and counters.
package nv_fifo_ctrl_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 4;
  localparam int unsigned CNTW  = 5;

  typedef logic [AW-1:0]   ptr_t;
  typedef logic [CNTW-1:0] cnt_t;

  // Occupancy of the two-stage read pipe
  typedef struct packed {
    logic s1_vld;  // read address latched in RAM
    logic s2_vld;  // read data held in RAM output register
  } rd_pipe_t;

endpackage

// File: rtl/nv_fifo_ctrl_16x256_if.sv
// Handshake and RAM-side bus of the FIFO controller.
// slave : controller view (takes write/read requests and RAM data, drives RAM controls)
// master: environment view (upstream writer, downstream reader and RAM)
interface nv_fifo_ctrl_16x256_if #(
  parameter int unsigned DW = nv_fifo_ctrl_pkg::DW
);
  import nv_fifo_ctrl_pkg::*;

  logic          flush;
  logic          wr_pvld;
  logic          wr_prdy;
  logic          rd_pvld;
  logic          rd_prdy;
  logic [DW-1:0] rd_pd;
  logic          ram_we;
  ptr_t          ram_wa;
  logic          ram_re;
  ptr_t          ram_ra;
  logic          ram_ore;
  logic [DW-1:0] ram_dout;
  cnt_t          fifo_count;

  modport slave (
    input  flush, wr_pvld, rd_prdy, ram_dout,
    output wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_re, ram_ra, ram_ore, fifo_count
  );

  modport master (
    output flush, wr_pvld, rd_prdy, ram_dout,
    input  wr_prdy, rd_pvld, rd_pd, ram_we, ram_wa, ram_re, ram_ra, ram_ore, fifo_count
  );

endinterface

// File: rtl/nv_fifo_ctrl_rd_pipe.sv
// Read pipe tracker: s1 = address held in RAM, s2 = data held in RAM output register.
// Ports: clk, reset (async active-high), flush, pend_nz (unissued entries exist),
//        rd_prdy; outputs ram_re, ram_ore (combinational enables) and s2_vld.
module nv_fifo_ctrl_rd_pipe
  import nv_fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic pend_nz,
  input  logic rd_prdy,
  output logic ram_re,
  output logic ram_ore,
  output logic s2_vld
);

  rd_pipe_t st_q;
  rd_pipe_t st_d;

  // Pipe state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q <= '0;
    end else begin
      st_q <= st_d;
    end
  end

  // Enables and next pipe state; a stage advances only when the one ahead frees up
  always_comb begin
    st_d    = st_q;
    ram_ore = st_q.s1_vld && (!st_q.s2_vld || rd_prdy) && !flush;
    ram_re  = pend_nz && (!st_q.s1_vld || ram_ore) && !flush;
    if (flush) begin
      st_d = '0;
    end else begin
      if (ram_re) begin
        st_d.s1_vld = 1'b1;
      end else if (ram_ore) begin
        st_d.s1_vld = 1'b0;
      end
      if (ram_ore) begin
        st_d.s2_vld = 1'b1;
      end else if (st_q.s2_vld && rd_prdy) begin
        st_d.s2_vld = 1'b0;
      end
    end
  end

  assign s2_vld = st_q.s2_vld;

endmodule

// File: rtl/nv_fifo_ctrl_16x256.sv
// FIFO controller for an external 16x256 RAM with registered read address and
// registered output. Tracks write/issue/pop pointers and drives RAM controls.
// Ports: clk, reset (async active-high), io (nv_fifo_ctrl_16x256_if.slave):
//   flush, wr_pvld/wr_prdy, rd_pvld/rd_prdy/rd_pd, ram_we/ram_wa,
//   ram_re/ram_ra, ram_ore, ram_dout, fifo_count.
// Build option: define NV_FIFO_CTRL_COUNT_EN to drive fifo_count with the
// occupancy; otherwise fifo_count is tied to 0.
module nv_fifo_ctrl_16x256 #(
  parameter int unsigned DEPTH = nv_fifo_ctrl_pkg::DEPTH,
  parameter int unsigned DW    = nv_fifo_ctrl_pkg::DW
) (
  input  logic                  clk,
  input  logic                  reset,
  nv_fifo_ctrl_16x256_if.slave  io
);
  import nv_fifo_ctrl_pkg::*;

  ptr_t wptr_q, wptr_d;
  ptr_t iptr_q, iptr_d;
  ptr_t pptr_q, pptr_d;
  cnt_t occ_q, occ_d;
  cnt_t pend_q, pend_d;

  logic wr_prdy_c;
  logic wr_acc_c;
  logic pop_c;
  logic ram_re_c;
  logic ram_ore_c;
  logic s2_vld;

  // Ready depends only on occupancy and flush; reset gate keeps it low while held
  assign wr_prdy_c = !reset && (occ_q != CNTW'(DEPTH)) && !io.flush;
  assign wr_acc_c  = io.wr_pvld && wr_prdy_c;
  assign pop_c     = s2_vld && io.rd_prdy && !io.flush;

  nv_fifo_ctrl_rd_pipe u_rd_pipe (
    .clk     (clk),
    .reset   (reset),
    .flush   (io.flush),
    .pend_nz (pend_q != '0),
    .rd_prdy (io.rd_prdy),
    .ram_re  (ram_re_c),
    .ram_ore (ram_ore_c),
    .s2_vld  (s2_vld)
  );

  // Pointer and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      iptr_q <= '0;
      pptr_q <= '0;
      occ_q  <= '0;
      pend_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      iptr_q <= iptr_d;
      pptr_q <= pptr_d;
      occ_q  <= occ_d;
      pend_q <= pend_d;
    end
  end

  // Next pointers/counters; flush wins over any same-cycle write or pop
  always_comb begin
    wptr_d = wptr_q;
    iptr_d = iptr_q;
    pptr_d = pptr_q;
    occ_d  = occ_q;
    pend_d = pend_q;
    if (io.flush) begin
      wptr_d = '0;
      iptr_d = '0;
      pptr_d = '0;
      occ_d  = '0;
      pend_d = '0;
    end else begin
      if (wr_acc_c) wptr_d = wptr_q + ptr_t'(1);
      if (ram_re_c) iptr_d = iptr_q + ptr_t'(1);
      if (pop_c)    pptr_d = pptr_q + ptr_t'(1);
      occ_d  = occ_q  + CNTW'(wr_acc_c) - CNTW'(pop_c);
      pend_d = pend_q + CNTW'(wr_acc_c) - CNTW'(ram_re_c);
    end
  end

  assign io.wr_prdy = wr_prdy_c;
  assign io.ram_we  = wr_acc_c;
  assign io.ram_wa  = wptr_q;
  assign io.ram_re  = ram_re_c;
  assign io.ram_ra  = iptr_q;
  assign io.ram_ore = ram_ore_c;
  assign io.rd_pvld = s2_vld;
  assign io.rd_pd   = DW'(io.ram_dout);

`ifdef NV_FIFO_CTRL_COUNT_EN
  assign io.fifo_count = occ_q;
`else
  assign io.fifo_count = '0;
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_16x256.sv
// Self-checking bench for nv_fifo_ctrl_16x256 with a behavioural RAM model.
module tb_nv_fifo_ctrl_16x256;
  import nv_fifo_ctrl_pkg::*;

`ifdef NV_FIFO_CTRL_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nv_fifo_ctrl_16x256_if #(.DW(DW)) bus();

  nv_fifo_ctrl_16x256 #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (bus)
  );

  // RAM: registered read address, registered output
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ra_q;
  logic [DW-1:0] dout_q;
  logic [DW-1:0] wr_data;
  always @(posedge clk) begin
    if (bus.ram_we)  mem[bus.ram_wa] <= wr_data;
    if (bus.ram_re)  ra_q <= bus.ram_ra;
    if (bus.ram_ore) dout_q <= mem[ra_q];
  end
  assign bus.ram_dout = dout_q;

  // Scoreboard: accepted writes and popped reads
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  always @(negedge clk) begin
    if (bus.ram_we) exp_q.push_back(wr_data);
    if (bus.rd_pvld && bus.rd_prdy) got_q.push_back(bus.rd_pd);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.flush = 1'b0; bus.wr_pvld = 1'b1; bus.rd_prdy = 1'b0;
    wr_data = '0;
    next(); next();
    #1;
    n_vec++; if (bus.wr_prdy !== 1'b0) begin n_err++; $display("FAIL reset_wr_prdy got %b want 0", bus.wr_prdy); end
    n_vec++; if (bus.ram_we !== 1'b0) begin n_err++; $display("FAIL reset_ram_we got %b want 0", bus.ram_we); end
    n_vec++; if ({bus.rd_pvld, bus.ram_re, bus.ram_ore} !== 3'b000) begin n_err++; $display("FAIL reset_ctrl got %b want 000", {bus.rd_pvld, bus.ram_re, bus.ram_ore}); end
    n_vec++; if ({bus.ram_wa, bus.ram_ra, bus.fifo_count} !== 13'd0) begin n_err++; $display("FAIL reset_addr_cnt got %h want 0", {bus.ram_wa, bus.ram_ra, bus.fifo_count}); end
    next();
    reset = 1'b0; bus.wr_pvld = 1'b0;
    #1;
    n_vec++; if (bus.wr_prdy !== 1'b1) begin n_err++; $display("FAIL release_wr_prdy got %b want 1", bus.wr_prdy); end
  endtask

  task automatic test_latency();
    logic [DW-1:0] a5 = {(DW/8){8'hA5}};
    logic [DW-1:0] e, g;
    next();
    bus.rd_prdy = 1'b1; bus.wr_pvld = 1'b1; wr_data = a5;
    #1;
    n_vec++; if (bus.ram_we !== 1'b1) begin n_err++; $display("FAIL lat_accept got %b want 1", bus.ram_we); end
    next();
    bus.wr_pvld = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_vec++; if (bus.rd_pvld !== (k == 3)) begin n_err++; $display("FAIL lat_rd_pvld_c%0d got %b want %b", k, bus.rd_pvld, (k == 3)); end
      if (k == 1) begin n_vec++; if ({bus.ram_re, bus.ram_ra} !== 5'b1_0000) begin n_err++; $display("FAIL lat_re got %b want 10000", {bus.ram_re, bus.ram_ra}); end end
      if (k == 2) begin n_vec++; if (bus.ram_ore !== 1'b1) begin n_err++; $display("FAIL lat_ore got %b want 1", bus.ram_ore); end end
      if (k == 3) begin n_vec++; if (bus.rd_pd !== a5) begin n_err++; $display("FAIL lat_rd_pd got %h want %h", bus.rd_pd, a5); end end
      next();
    end
    #1;
    n_vec++; if (bus.rd_pvld !== 1'b0) begin n_err++; $display("FAIL lat_after got %b want 0", bus.rd_pvld); end
    n_vec++; if (got_q.size() != exp_q.size()) begin n_err++; $display("FAIL lat_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL lat_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_full();
    logic [DW-1:0] e, g;
    int acc = 0;
    next();
    bus.rd_prdy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
      #1; if (bus.ram_we === 1'b1) acc++;
      next();
    end
    n_vec++; if (acc != 16) begin n_err++; $display("FAIL full_accepts got %0d want 16", acc); end
    bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
    #1;
    n_vec++; if ({bus.wr_prdy, bus.ram_we} !== 2'b00) begin n_err++; $display("FAIL full_prdy got %b want 00", {bus.wr_prdy, bus.ram_we}); end
    n_vec++; if (bus.fifo_count !== CNTW'(CNT_EN ? 16 : 0)) begin n_err++; $display("FAIL full_count got %0d want %0d", bus.fifo_count, CNT_EN ? 16 : 0); end
    next();
    bus.rd_prdy = 1'b1;
    #1;
    n_vec++; if ({bus.rd_pvld, bus.wr_prdy} !== 2'b10) begin n_err++; $display("FAIL full_pop_cycle got %b want 10", {bus.rd_pvld, bus.wr_prdy}); end
    next();
    bus.rd_prdy = 1'b0; bus.wr_pvld = 1'b0;
    #1;
    n_vec++; if (bus.wr_prdy !== 1'b1) begin n_err++; $display("FAIL full_after_pop got %b want 1", bus.wr_prdy); end
    n_vec++; if (bus.fifo_count !== CNTW'(CNT_EN ? 15 : 0)) begin n_err++; $display("FAIL full_count15 got %0d want %0d", bus.fifo_count, CNT_EN ? 15 : 0); end
    next();
    bus.rd_prdy = 1'b1;
    for (int i = 0; i < 25; i++) next();
    n_vec++; if (got_q.size() != 16 || exp_q.size() != 16) begin n_err++; $display("FAIL full_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL full_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e, g;
    int pops = 0, first = -1, last = -1;
    bit wrapped = 1'b0;
    logic [AW-1:0] prev_wa = '0;
    bus.rd_prdy = 1'b1;
    for (int c = 0; c < 46; c++) begin
      bus.wr_pvld = (c < 40); wr_data = {(DW/32){$urandom()}};
      #1;
      if (c < 40) begin
        n_vec++; if ({bus.ram_we, bus.ram_wa} !== {1'b1, AW'(1 + c)}) begin n_err++; $display("FAIL b2b_wr_c%0d got %b want %b", c, {bus.ram_we, bus.ram_wa}, {1'b1, AW'(1 + c)}); end
        if (c > 0 && prev_wa == 4'd15 && bus.ram_wa == 4'd0) wrapped = 1'b1;
        prev_wa = bus.ram_wa;
      end
      if (bus.rd_pvld === 1'b1) begin
        pops++; last = c;
        if (first < 0) first = c;
      end
      next();
    end
    n_vec++; if (!wrapped) begin n_err++; $display("FAIL b2b_wrap got 0 want 1"); end
    n_vec++; if (pops != 40 || last - first != 39) begin n_err++; $display("FAIL b2b_rate got %0d pops over %0d cycles want 40 over 40", pops, last - first + 1); end
    n_vec++; if (got_q.size() != 40 || exp_q.size() != 40) begin n_err++; $display("FAIL b2b_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL b2b_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_stall();
    logic [DW-1:0] e, g, prev_pd;
    logic [3:0] pat = 4'b1001;
    bit prev_stall = 1'b0;
    int stalls = 0;
    prev_pd = '0;
    for (int c = 0; c < 40; c++) begin
      bus.rd_prdy = pat[c % 4]; bus.wr_pvld = (c < 6); wr_data = {(DW/32){$urandom()}};
      #1;
      if (prev_stall) begin
        stalls++;
        n_vec++; if ({bus.rd_pvld, bus.rd_pd} !== {1'b1, prev_pd}) begin n_err++; $display("FAIL stall_hold_c%0d got %h want %h", c, bus.rd_pd, prev_pd); end
      end
      prev_stall = bus.rd_pvld && !bus.rd_prdy;
      prev_pd = bus.rd_pd;
      next();
    end
    n_vec++; if (stalls == 0) begin n_err++; $display("FAIL stall_seen got 0 want >0"); end
    n_vec++; if (got_q.size() != 6 || exp_q.size() != 6) begin n_err++; $display("FAIL stall_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL stall_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_flush();
    logic [DW-1:0] e, g;
    int acc = 0;
    bus.rd_prdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
      next();
    end
    bus.wr_pvld = 1'b0;
    next(); next(); next();
    n_vec++; if (bus.rd_pvld !== 1'b1) begin n_err++; $display("FAIL flush_pre_pvld got %b want 1", bus.rd_pvld); end
    bus.flush = 1'b1; bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
    #1;
    n_vec++; if ({bus.wr_prdy, bus.ram_we, bus.ram_re, bus.ram_ore} !== 4'b0000) begin n_err++; $display("FAIL flush_cycle got %b want 0000", {bus.wr_prdy, bus.ram_we, bus.ram_re, bus.ram_ore}); end
    next();
    bus.flush = 1'b0; bus.wr_pvld = 1'b0;
    #1;
    n_vec++; if ({bus.rd_pvld, bus.fifo_count, bus.ram_wa, bus.ram_ra} !== 14'd0) begin n_err++; $display("FAIL flush_after got %h want 0", {bus.rd_pvld, bus.fifo_count, bus.ram_wa, bus.ram_ra}); end
    exp_q.delete(); got_q.delete();
    // occupancy must restart from zero: exactly 16 more writes fit
    for (int c = 0; c < 20; c++) begin
      bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
      #1; if (bus.ram_we === 1'b1) acc++;
      next();
    end
    bus.wr_pvld = 1'b0;
    n_vec++; if (acc != 16) begin n_err++; $display("FAIL flush_refill got %0d want 16", acc); end
    bus.rd_prdy = 1'b1;
    for (int i = 0; i < 25; i++) next();
    n_vec++; if (got_q.size() != 16 || exp_q.size() != 16) begin n_err++; $display("FAIL flush_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL flush_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e, g;
    bus.rd_prdy = 1'b1;
    for (int c = 0; c < 6; c++) begin
      bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
      next();
    end
    reset = 1'b1;
    #1;
    n_vec++; if ({bus.wr_prdy, bus.rd_pvld, bus.ram_we, bus.ram_re, bus.ram_ore} !== 5'b0) begin n_err++; $display("FAIL rstmid_ctrl got %b want 00000", {bus.wr_prdy, bus.rd_pvld, bus.ram_we, bus.ram_re, bus.ram_ore}); end
    n_vec++; if ({bus.ram_wa, bus.ram_ra, bus.fifo_count} !== 13'd0) begin n_err++; $display("FAIL rstmid_addr got %h want 0", {bus.ram_wa, bus.ram_ra, bus.fifo_count}); end
    bus.wr_pvld = 1'b0;
    next(); next();
    exp_q.delete(); got_q.delete();
    reset = 1'b0; bus.wr_pvld = 1'b1; wr_data = {(DW/32){$urandom()}};
    #1;
    n_vec++; if ({bus.wr_prdy, bus.ram_we, bus.ram_wa} !== 6'b11_0000) begin n_err++; $display("FAIL rstmid_first_wr got %b want 110000", {bus.wr_prdy, bus.ram_we, bus.ram_wa}); end
    next();
    bus.wr_pvld = 1'b0;
    #1;
    n_vec++; if ({bus.ram_re, bus.ram_ra} !== 5'b1_0000) begin n_err++; $display("FAIL rstmid_ra got %b want 10000", {bus.ram_re, bus.ram_ra}); end
    for (int i = 0; i < 8; i++) next();
    n_vec++; if (got_q.size() != 1 || exp_q.size() != 1) begin n_err++; $display("FAIL rstmid_sb_count got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      n_vec++; if (g !== e) begin n_err++; $display("FAIL rstmid_sb_data got %h want %h", g, e); end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
